light_seq: RTL and testbench
============================

LIGHT_SEQ -- requirements
Module: light_seq

Interface
REQ-001 Parameter N_DIR, default 2, SHALL set the number of approach directions served in rotation; legal range 2..8.
REQ-002 Parameter CNT_W, default 8, SHALL set the phase timer width in bits.
REQ-003 Parameter T_LEFT, default 8, SHALL set the protected-left phase length in clock cycles.
REQ-004 Parameter T_GREEN, default 20, SHALL set the through-green phase length in clock cycles.
REQ-005 Parameter T_YELLOW, default 4, SHALL set the yellow phase length in clock cycles.
REQ-006 Parameter T_ALLRED, default 2, SHALL set the all-red clearance length in clock cycles.
REQ-007 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port en, input, 1 bit: run enable; 0 freezes the sequence.
REQ-010 Port force_red, input, 1 bit: emergency all-red request, level-sensitive.
REQ-011 Port left_en, input, N_DIR bits: bit d enables the protected-left phase for direction d.
REQ-012 Ports red, yellow, green, left, output, N_DIR bits each: lamp drives, bit d for direction d.
REQ-013 Port phase, output, 2 bits: current phase code (ALLRED=0, LEFT=1, GREEN=2, YELLOW=3).
REQ-014 Port cur_dir, output, max(1,$clog2(N_DIR)) bits: index of the direction being served.
REQ-015 Port cycle_done, output, 1 bit: one-cycle pulse at the end of a full rotation.

Function
REQ-016 The FSM SHALL have four states: ALLRED, LEFT, GREEN, YELLOW.
REQ-017 Transitions: ALLRED->LEFT if left_en[cur_dir], else ALLRED->GREEN; LEFT->GREEN; GREEN->YELLOW; YELLOW->ALLRED.
REQ-018 left_en SHALL be sampled only on the ALLRED exit edge; changes during LEFT/GREEN/YELLOW have no effect.
REQ-019 Each phase SHALL last exactly its T_* cycles with en=1. On entry, the timer loads T_*-1. It decrements each enabled cycle. The transition occurs on the edge where the timer is 0.
REQ-020 On the YELLOW->ALLRED edge, cur_dir SHALL increment, wrapping from N_DIR-1 to 0.
REQ-021 On that wrap edge, cycle_done SHALL be 1 for exactly one cycle; otherwise cycle_done is 0.
REQ-022 Lamp decode for cur_dir, per phase:
  - ALLRED: red=1.
  - LEFT: green=1, left=1.
  - GREEN: green=1.
  - YELLOW: yellow=1.
  - All other lamp bits of cur_dir are 0. Every other direction shows red=1 only.
REQ-023 Outputs SHALL be registered and SHALL change on the same edge as the state register, with no combinational path from inputs to outputs.
REQ-024 At most one direction SHALL show a non-red lamp in any cycle. red and green SHALL never both be 1 for the same direction.
REQ-025 With en=0 and force_red=0, state, timer, cur_dir and outputs SHALL hold; cycle_done SHALL be 0.
REQ-026 force_red=1 in any state SHALL force, on the next edge:
  - ALLRED, all-red outputs, timer reloaded to T_ALLRED-1;
  - cur_dir unchanged, so the interrupted direction restarts from its first phase;
  - cycle_done=0.
REQ-027 While force_red=1, the timer SHALL hold at T_ALLRED-1. After release, ALLRED SHALL last T_ALLRED more cycles.
REQ-028 force_red SHALL take priority over en=0.
REQ-029 A T_* of 0 or above 2^CNT_W, or N_DIR outside 2..8, SHALL be rejected by an elaboration-time check.

Reset
REQ-030 Asserting reset SHALL immediately set:
  - state ALLRED, timer T_ALLRED-1, cur_dir 0;
  - red all 1s; yellow, green, left all 0s;
  - phase 0, cycle_done 0.
REQ-031 Reset mid-phase SHALL discard the phase. After deassertion the sequence SHALL restart with ALLRED for direction 0.

Structure
REQ-032 Package light_pkg SHALL hold the phase codes as localparams and the parameter-range check helper.
REQ-033 A sub-module phase_timer SHALL implement the CNT_W-bit down-counter:
  - inputs: load, load_val, dec, hold;
  - output: zero flag.
  light_seq SHALL instantiate it once.

Verification
Scenarios use N_DIR=2, T_LEFT=3, T_GREEN=5, T_YELLOW=2, T_ALLRED=1 unless stated.
REQ-034 Reset release, en=1, left_en=00 -> dir0: ALLRED 1 cycle, GREEN 5, YELLOW 2; then ALLRED 1 with cur_dir=1; dir1: GREEN 5, YELLOW 2; cycle_done pulses once at cycle 16.
REQ-035 left_en=01 -> dir0 shows green+left for 3 cycles, then green 5, yellow 2; dir1 skips LEFT.
REQ-036 en=0 for 4 cycles mid-GREEN -> outputs frozen; GREEN total still 5 enabled cycles.
REQ-037 force_red=1 at GREEN cycle 3 of dir1, held 6 cycles -> all red on the next edge and for 6 cycles; then 1 ALLRED cycle; then dir1 GREEN for a full 5 cycles.
REQ-038 reset pulse asserted mid-YELLOW without a clock edge -> outputs all-red immediately; cur_dir=0.
REQ-039 N_DIR=4 with left_en=1010 -> rotation 0,1,2,3,0; LEFT only on dirs 1 and 3; a checker confirms REQ-024 every cycle.

Source files
------------

// File: rtl/light_pkg.sv
// Shared phase codes, FSM state type and parameter-legality helpers
// for the traffic light sequencer.
package light_pkg;

  localparam logic [1:0] PH_ALLRED = 2'd0;
  localparam logic [1:0] PH_LEFT   = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  typedef enum logic [1:0] {
    ST_ALLRED = PH_ALLRED,
    ST_LEFT   = PH_LEFT,
    ST_GREEN  = PH_GREEN,
    ST_YELLOW = PH_YELLOW
  } state_e;

  // A phase length of t cycles loads t-1, so t may reach 2**cnt_w.
  function automatic bit time_ok(input int t, input int cnt_w);
    return (t >= 1) && (longint'(t) <= (longint'(1) << cnt_w));
  endfunction

  function automatic bit ndir_ok(input int n);
    return (n >= 2) && (n <= 8);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter measuring how long the sequencer stays in one phase;
// zero marks the last cycle of the phase.
module phase_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             hold,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over counting; the counter never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && !hold && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/light_seq.sv
// Intersection light sequencer: serves N_DIR approaches in rotation through
// ALLRED, optional protected LEFT, GREEN and YELLOW, with an emergency all-red.
module light_seq
  import light_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int CNT_W    = 8,
  parameter int T_LEFT   = 8,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2,
  localparam int DW      = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             force_red,
  input  logic [N_DIR-1:0] left_en,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [N_DIR-1:0] left,
  output logic [1:0]       phase,
  output logic [DW-1:0]    cur_dir,
  output logic             cycle_done
);

  if (!ndir_ok(N_DIR) || !time_ok(T_LEFT, CNT_W) || !time_ok(T_GREEN, CNT_W) ||
      !time_ok(T_YELLOW, CNT_W) || !time_ok(T_ALLRED, CNT_W)) begin : g_param_err
    $error("light_seq: illegal N_DIR or phase length for CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_LEFT   = CNT_W'(T_LEFT - 1);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [DW-1:0]    DIR_LAST  = DW'(N_DIR - 1);

  state_e             state_q, state_d;
  logic [DW-1:0]      dir_q, dir_d;
  logic               done_q, done_d;
  logic [N_DIR-1:0]   red_q, red_d, yellow_q, yellow_d;
  logic [N_DIR-1:0]   green_q, green_d, left_q, left_d;
  logic               tLoad, tDec, tHold, tZero;
  logic [CNT_W-1:0]   tLoadVal;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALLRED)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tLoad),
    .load_val (tLoadVal),
    .dec      (tDec),
    .hold     (tHold),
    .zero     (tZero)
  );

  // Emergency red beats the enable; a phase ends on the edge its timer reads 0.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    tLoad    = 1'b0;
    tLoadVal = LD_ALLRED;
    tDec     = 1'b0;
    tHold    = 1'b0;
    if (force_red) begin
      state_d = ST_ALLRED;
      tLoad   = 1'b1;
    end else if (!en) begin
      tHold = 1'b1;
    end else if (!tZero) begin
      tDec = 1'b1;
    end else begin
      tLoad = 1'b1;
      case (state_q)
        ST_ALLRED: begin
          if (left_en[dir_q]) begin
            state_d  = ST_LEFT;
            tLoadVal = LD_LEFT;
          end else begin
            state_d  = ST_GREEN;
            tLoadVal = LD_GREEN;
          end
        end
        ST_LEFT: begin
          state_d  = ST_GREEN;
          tLoadVal = LD_GREEN;
        end
        ST_GREEN: begin
          state_d  = ST_YELLOW;
          tLoadVal = LD_YELLOW;
        end
        default: begin
          state_d  = ST_ALLRED;
          tLoadVal = LD_ALLRED;
          if (dir_q == DIR_LAST) begin
            dir_d  = '0;
            done_d = 1'b1;
          end else begin
            dir_d = dir_q + DW'(1);
          end
        end
      endcase
    end
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    left_d   = '0;
    case (state_d)
      ST_LEFT: begin
        red_d[dir_d]   = 1'b0;
        green_d[dir_d] = 1'b1;
        left_d[dir_d]  = 1'b1;
      end
      ST_GREEN: begin
        red_d[dir_d]   = 1'b0;
        green_d[dir_d] = 1'b1;
      end
      ST_YELLOW: begin
        red_d[dir_d]    = 1'b0;
        yellow_d[dir_d] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ALLRED;
      dir_q    <= '0;
      done_q   <= 1'b0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
      left_q   <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      left_q   <= left_d;
    end
  end

  assign red        = red_q;
  assign yellow     = yellow_q;
  assign green      = green_q;
  assign left       = left_q;
  assign phase      = state_q;
  assign cur_dir    = dir_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_light_seq.sv
// Randomized scoreboard bench for light_seq: a phase/remaining-cycles model
// predicts each edge, a monitor pops the prediction and checks the lamps.
module tb_light_seq;

  localparam int ND       = 4;
  localparam int DW       = 2;
  localparam int T_LEFT   = 3;
  localparam int T_GREEN  = 5;
  localparam int T_YELLOW = 2;
  localparam int T_ALLRED = 1;

  typedef struct {
    int ph;
    int dir;
    bit done;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          force_red = 1'b0;
  logic [ND-1:0] left_en = '0;
  logic [ND-1:0] red, yellow, green, left;
  logic [1:0]    phase;
  logic [DW-1:0] cur_dir;
  logic          cycle_done;

  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t sbq[$];
  int   mPhase, mRem, mDir;
  bit   mDone;
  int   edgeIdx = 0;
  int   firstDone = 0;
  logic [ND-1:0] leftSeen = '0;

  light_seq #(
    .N_DIR    (ND),
    .CNT_W    (8),
    .T_LEFT   (T_LEFT),
    .T_GREEN  (T_GREEN),
    .T_YELLOW (T_YELLOW),
    .T_ALLRED (T_ALLRED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .force_red  (force_red),
    .left_en    (left_en),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .left       (left),
    .phase      (phase),
    .cur_dir    (cur_dir),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int phaseLen(input int ph);
    case (ph)
      0:       return T_ALLRED;
      1:       return T_LEFT;
      2:       return T_GREEN;
      default: return T_YELLOW;
    endcase
  endfunction

  task automatic modelReset();
    mPhase = 0;
    mRem   = T_ALLRED;
    mDir   = 0;
    mDone  = 1'b0;
  endtask

  // mRem counts the enabled cycles still to be spent in the current phase.
  task automatic modelStep(input bit e, input bit f, input logic [ND-1:0] le);
    mDone = 1'b0;
    if (f) begin
      mPhase = 0;
      mRem   = T_ALLRED;
    end else if (e) begin
      mRem--;
      if (mRem == 0) begin
        case (mPhase)
          0: mPhase = le[mDir] ? 1 : 2;
          1: mPhase = 2;
          2: mPhase = 3;
          default: begin
            mPhase = 0;
            mDir   = (mDir + 1) % ND;
            mDone  = (mDir == 0);
          end
        endcase
        mRem = phaseLen(mPhase);
      end
    end
  endtask

  task automatic applyStimulus(input bit e, input bit f, input logic [ND-1:0] le);
    exp_t item;
    en        = e;
    force_red = f;
    left_en   = le;
    modelStep(e, f, le);
    item.ph   = mPhase;
    item.dir  = mDir;
    item.done = mDone;
    @(posedge clk);
    sbq.push_back(item);
    #1;
  endtask

  // Monitor: compares every predicted edge against the registered outputs.
  initial begin
    exp_t e;
    logic [ND-1:0] eRed, eYel, eGrn, eLft, nonRed;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        edgeIdx++;
        eRed = '1; eYel = '0; eGrn = '0; eLft = '0;
        if (e.ph != 0) eRed[e.dir] = 1'b0;
        if (e.ph == 1 || e.ph == 2) eGrn[e.dir] = 1'b1;
        if (e.ph == 1) eLft[e.dir] = 1'b1;
        if (e.ph == 3) eYel[e.dir] = 1'b1;
        checkOutput("phase", 32'(phase), e.ph);
        checkOutput("cur_dir", 32'(cur_dir), e.dir);
        checkOutput("cycle_done", 32'(cycle_done), 32'(e.done));
        checkOutput("red", 32'(red), 32'(eRed));
        checkOutput("yellow", 32'(yellow), 32'(eYel));
        checkOutput("green", 32'(green), 32'(eGrn));
        checkOutput("left", 32'(left), 32'(eLft));
        nonRed = ~red | yellow | green | left;
        checkOutput("one_active", 32'($countones(nonRed) <= 1), 32'd1);
        checkOutput("red_green_excl", 32'(red & green), 32'd0);
        if (cycle_done === 1'b1 && firstDone == 0) firstDone = edgeIdx;
        leftSeen |= left;
      end
    end
  end

  initial begin
    int forceLeft;
    bit f;
    modelReset();
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_red", 32'(red), 32'hF);
    checkOutput("rst_yellow", 32'(yellow), 32'h0);
    checkOutput("rst_green", 32'(green), 32'h0);
    checkOutput("rst_phase", 32'(phase), 32'h0);
    checkOutput("rst_cur_dir", 32'(cur_dir), 32'h0);
    checkOutput("rst_cycle_done", 32'(cycle_done), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Plain rotation without protected lefts: one rotation is 4*(1+5+2) edges.
    edgeIdx   = 0;
    firstDone = 0;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("first_cycle_done_edge", firstDone, 32);

    // Protected left on directions 1 and 3 only.
    leftSeen = '0;
    for (int i = 0; i < 80; i++) applyStimulus(1'b1, 1'b0, 4'b1010);
    checkOutput("left_dirs_seen", 32'(leftSeen), 32'hA);

    // Random enables, emergency holds and left requests changing every cycle.
    forceLeft = 0;
    for (int i = 0; i < 700; i++) begin
      if (forceLeft == 0 && $urandom_range(0, 39) == 0) forceLeft = $urandom_range(1, 6);
      f = (forceLeft > 0);
      if (forceLeft > 0) forceLeft--;
      applyStimulus($urandom_range(0, 9) != 0, f, ND'($urandom));
    end

    // Asynchronous reset while yellow is showing.
    for (int k = 0; k < 100 && mPhase != 3; k++) applyStimulus(1'b1, 1'b0, ND'($urandom));
    checkOutput("reached_yellow", mPhase, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_red", 32'(red), 32'hF);
    checkOutput("mid_rst_yellow", 32'(yellow), 32'h0);
    checkOutput("mid_rst_green", 32'(green | left), 32'h0);
    checkOutput("mid_rst_phase", 32'(phase), 32'h0);
    checkOutput("mid_rst_cur_dir", 32'(cur_dir), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, ND'($urandom));

    #3;
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
